// File: rtl/pdl_dll_ctrl_pkg.sv
// Shared types, default geometry and the code-to-thermometer helper for the PDL DLL controller.
package pdl_dll_ctrl_pkg;

  localparam int unsigned PDL_NTAPS  = 64;
  localparam int unsigned PDL_CODE_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    STEP,
    OVRD
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DN
  } dir_t;

  function automatic logic [PDL_NTAPS-1:0] therm(input int unsigned c);
    logic [PDL_NTAPS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < PDL_NTAPS; i++) begin
      t[i] = (i < c);
    end
    return t;
  endfunction

endpackage

// File: rtl/pdl_therm_enc.sv
// Registered code-to-thermometer encoder; owns the bk flop (bk[i]=1 iff i<code).
module pdl_therm_enc #(
  parameter int unsigned       NTAPS  = 64,
  parameter int unsigned       CODE_W = 7,
  parameter logic [NTAPS-1:0]  RST_BK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] i_code,
  output logic [NTAPS-1:0]  o_bk
);

  logic [NTAPS-1:0] w_bk_d;
  logic [NTAPS-1:0] r_bk;

  always_comb begin
    w_bk_d = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      w_bk_d[i] = (i < 32'(i_code));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_bk <= RST_BK;
    else     r_bk <= w_bk_d;
  end

  assign o_bk = r_bk;

endmodule

// File: rtl/pdl_dll_ctrl.sv
// Closed-loop PDL tap calibration: vote filter, +/-1 code stepping, reversal-based lock, override.
// Optional lock-loss detection enabled by defining PDL_DLL_CTRL_LOCK_LOSS_EN.
module pdl_dll_ctrl
  import pdl_dll_ctrl_pkg::*;
#(
  parameter int unsigned NTAPS      = PDL_NTAPS,
  parameter int unsigned CODE_W     = PDL_CODE_W,
  parameter int unsigned INIT_CODE  = 32,
  parameter int unsigned FILT_THR   = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned LOCK_REV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_en,
  input  logic              pd_valid,
  input  logic              pd_late,
  input  logic              ovrd_en,
  input  logic [CODE_W-1:0] ovrd_code,
  output logic [NTAPS-1:0]  bk,
  output logic [CODE_W-1:0] code,
  output logic              locked,
  output logic              busy
);

  localparam int unsigned VOTE_W = $clog2(FILT_THR) + 2;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned REV_W  = $clog2(LOCK_REV + 1);

  localparam logic signed [VOTE_W-1:0] VOTE_THR = VOTE_W'(FILT_THR);
  localparam logic signed [VOTE_W-1:0] VOTE_ONE = VOTE_W'(1);
  localparam logic [CODE_W-1:0]        CODE_MAX = CODE_W'(NTAPS);
  localparam logic [CODE_W-1:0]        CODE_ONE = CODE_W'(1);
  localparam logic [SET_W-1:0]         SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [REV_W-1:0]         REV_LOCK = REV_W'(LOCK_REV);
  // The package helper is sized for the default line length.
  localparam logic [NTAPS-1:0]         RST_BK   = NTAPS'(therm(INIT_CODE));

  state_t                    r_state, w_state_nxt;
  logic [CODE_W-1:0]         r_code;
  logic signed [VOTE_W-1:0]  r_vote, w_vote_nxt;
  logic [REV_W-1:0]          r_rev;
  dir_t                      r_dir, w_dir;
  logic                      r_locked;
  logic [SET_W-1:0]          r_settle;
  logic                      w_vote_hit, w_up, w_sat, w_rev_hit, w_busy;
  logic [CODE_W-1:0]         w_tgt;

`ifdef PDL_DLL_CTRL_LOCK_LOSS_EN
  logic [CODE_W-1:0] r_lock_code;
  logic [CODE_W-1:0] w_diff;
  logic              w_drift;
  assign w_diff  = (r_code > r_lock_code) ? r_code - r_lock_code : r_lock_code - r_code;
  assign w_drift = r_locked && (w_diff > CODE_W'(2));
`endif

  assign w_vote_nxt = pd_late ? r_vote - VOTE_ONE : r_vote + VOTE_ONE;
  assign w_vote_hit = (w_vote_nxt == VOTE_THR) || (w_vote_nxt == -VOTE_THR);
  assign w_up       = ~r_vote[VOTE_W-1];
  assign w_dir      = w_up ? UP : DN;
  assign w_sat      = w_up ? (r_code == CODE_MAX) : (r_code == '0);
  // The first step after a clear has no previous direction and is never a reversal.
  assign w_rev_hit  = !w_sat && (r_dir != NONE) && (w_dir != r_dir);
  assign w_tgt      = (ovrd_code > CODE_MAX) ? CODE_MAX : ovrd_code;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ovrd_en)      w_state_nxt = OVRD;
    else if (!cal_en) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    w_state_nxt = SETTLE;
        SETTLE:  if (r_settle == SET_LAST) w_state_nxt = ACCUM;
        ACCUM:   if (pd_valid && w_vote_hit) w_state_nxt = STEP;
        STEP:    w_state_nxt = SETTLE;
        OVRD:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code   <= CODE_W'(INIT_CODE);
      r_vote   <= '0;
      r_rev    <= '0;
      r_dir    <= NONE;
      r_locked <= 1'b0;
      r_settle <= '0;
`ifdef PDL_DLL_CTRL_LOCK_LOSS_EN
      r_lock_code <= '0;
`endif
    end else begin
      r_settle <= (r_state == SETTLE) ? r_settle + SET_W'(1) : '0;
      if (ovrd_en) begin
        r_vote   <= '0;
        r_rev    <= '0;
        r_locked <= 1'b0;
        if (r_state == OVRD) begin
          if (r_code < w_tgt)      r_code <= r_code + CODE_ONE;
          else if (r_code > w_tgt) r_code <= r_code - CODE_ONE;
        end
      end else if (!cal_en) begin
        r_vote   <= '0;
        r_rev    <= '0;
        r_dir    <= NONE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ACCUM: if (pd_valid) r_vote <= w_vote_nxt;
          STEP: begin
            r_vote <= '0;
            r_dir  <= w_dir;
            if (!w_sat) r_code <= w_up ? r_code + CODE_ONE : r_code - CODE_ONE;
            if (w_rev_hit && (r_rev != REV_LOCK)) r_rev <= r_rev + REV_W'(1);
            if (w_rev_hit && (r_rev == REV_LOCK - REV_W'(1))) begin
              r_locked <= 1'b1;
`ifdef PDL_DLL_CTRL_LOCK_LOSS_EN
              r_lock_code <= w_up ? r_code + CODE_ONE : r_code - CODE_ONE;
`endif
            end
          end
          default: ;
        endcase
`ifdef PDL_DLL_CTRL_LOCK_LOSS_EN
        if (w_drift) begin
          r_locked <= 1'b0;
          r_rev    <= '0;
        end
`endif
      end
    end
  end

  pdl_therm_enc #(
    .NTAPS  (NTAPS),
    .CODE_W (CODE_W),
    .RST_BK (RST_BK)
  ) u_therm_enc (
    .clk    (clk),
    .rst    (rst),
    .i_code (r_code),
    .o_bk   (bk)
  );

  assign code   = r_code;
  assign locked = r_locked;
  assign busy   = w_busy;

endmodule

// File: tb/tb_pdl_dll_ctrl.sv
// Directed bench for pdl_dll_ctrl with hand-computed cycle-exact expectations.
module tb_pdl_dll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cal_en;
  logic        pd_valid;
  logic        pd_late;
  logic        ovrd_en;
  logic [6:0]  ovrd_code;
  logic [63:0] bk;
  logic [6:0]  code;
  logic        locked;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pdl_dll_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cal_en    (cal_en),
    .pd_valid  (pd_valid),
    .pd_late   (pd_late),
    .ovrd_en   (ovrd_en),
    .ovrd_code (ovrd_code),
    .bk        (bk),
    .code      (code),
    .locked    (locked),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Late while at 32, early otherwise: forces alternating decisions.
  task automatic run_alt(input int n);
    repeat (n) begin
      pd_late = (code == 7'd32);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] tb_therm(input int c);
    if (c >= 64) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << c) - 64'd1;
  endfunction

  initial begin
    int ecode;
    rst = 1'b1; cal_en = 1'b0; pd_valid = 1'b0; pd_late = 1'b0;
    ovrd_en = 1'b0; ovrd_code = '0;
    run(3);
    check("rst_code",   64'(code),   64'd32);
    check("rst_bk",     bk,          64'h0000_0000_FFFF_FFFF);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    rst = 1'b0;
    run(1);

    // Always early: step up once per 13 cycles after the initial idle cycle.
    cal_en = 1'b1; pd_valid = 1'b1; pd_late = 1'b0;
    run(1);
    check("busy_on", 64'(busy), 64'd1);
    run(12);
    check("pre_step_code", 64'(code), 64'd32);
    run(1);
    check("step1_code", 64'(code), 64'd33);
    check("step1_bk_lag", 64'(bk[32]), 64'd0);
    run(1);
    check("step1_bk", 64'(bk[32]), 64'd1);
    run(11);
    check("pre_step2_code", 64'(code), 64'd33);
    run(1);
    check("step2_code", 64'(code), 64'd34);

    // Override up to 62, then saturate at 64 with early votes.
    cal_en = 1'b0; ovrd_en = 1'b1; ovrd_code = 7'd62;
    run(40);
    check("ovrd62_code", 64'(code), 64'd62);
    ovrd_en = 1'b0; cal_en = 1'b1;
    run(15);
    check("sat_63", 64'(code), 64'd63);
    run(13);
    check("sat_64", 64'(code), 64'd64);
    run(1);
    check("sat_bk", bk, 64'hFFFF_FFFF_FFFF_FFFF);
    run(39);
    check("sat_hold", 64'(code), 64'd64);
    check("sat_bk_hold", bk, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back to 32, then alternate directions until lock.
    cal_en = 1'b0; ovrd_en = 1'b1; ovrd_code = 7'd32;
    run(40);
    check("ovrd32_code", 64'(code), 64'd32);
    ovrd_en = 1'b0;
    run(2);
    cal_en = 1'b1;
    run_alt(65);
    check("alt_pre_lock_code", 64'(code), 64'd32);
    check("alt_pre_lock", 64'(locked), 64'd0);
    run_alt(1);
    check("alt_lock_code", 64'(code), 64'd31);
    check("alt_locked", 64'(locked), 64'd1);
    run_alt(13);
    check("track_code", 64'(code), 64'd32);
    check("track_locked", 64'(locked), 64'd1);
    pd_late = 1'b0;
    run(39);
    check("drift_code", 64'(code), 64'd35);
`ifdef PDL_DLL_CTRL_LOCK_LOSS_EN
    check("drift_lock_lost", 64'(locked), 64'd0);
`else
    check("drift_lock_sticky", 64'(locked), 64'd1);
`endif

    // Drop cal_en mid-accumulation: votes must be discarded.
    cal_en = 1'b0;
    run(1);
    check("calen_off_locked", 64'(locked), 64'd0);
    check("calen_off_busy", 64'(busy), 64'd0);
    cal_en = 1'b1;
    run(11);
    check("accum_busy", 64'(busy), 64'd1);
    cal_en = 1'b0;
    run(1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_code", 64'(code), 64'd35);
    cal_en = 1'b1;
    run(13);
    check("fresh_pre_code", 64'(code), 64'd35);
    run(1);
    check("fresh_step_code", 64'(code), 64'd36);

    // Override walk 32 -> 10 one tap per cycle, bk trailing code by one cycle.
    ovrd_en = 1'b1; ovrd_code = 7'd32;
    run(10);
    check("ovrd_start_code", 64'(code), 64'd32);
    check("ovrd_locked", 64'(locked), 64'd0);
    ovrd_code = 7'd10;
    ecode = 32;
    for (int i = 0; i < 22; i++) begin
      run(1);
      check("ovrd_bk_trail", bk, tb_therm(ecode));
      ecode = ecode - 1;
      check("ovrd_walk_code", 64'(code), 64'(ecode));
    end
    run(1);
    check("ovrd_hold10", 64'(code), 64'd10);
    ovrd_code = 7'd100;
    run(60);
    check("ovrd_clamp_code", 64'(code), 64'd64);
    check("ovrd_clamp_bk", bk, 64'hFFFF_FFFF_FFFF_FFFF);
    run(3);
    check("ovrd_clamp_hold", 64'(code), 64'd64);
    ovrd_en = 1'b0; cal_en = 1'b0;
    run(2);
    check("ovrd_exit_busy", 64'(busy), 64'd0);
    check("ovrd_exit_code", 64'(code), 64'd64);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
